// File: rtl/key_debounce_multi_pkg.sv
// key_debounce_multi_pkg: default timing constants, long-press state type and sizing helper.
package key_debounce_multi_pkg;
  localparam int DEF_DEBOUNCE_CNT = 1_000_000;
  localparam int DEF_MS_CNT = 50_000;
  localparam int DEF_LONG_MS = 1000;
  typedef enum logic [1:0] {
    LP_IDLE,
    LP_HOLD,
    LP_DONE
  } lp_state_e;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- synchroniser, debounce filter and long-press detector.
module key_debounce_ch
  import key_debounce_multi_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int LONG_MS      = DEF_LONG_MS,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  input  logic tick,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);
  localparam int CW = cnt_width(DEBOUNCE_CNT);
  localparam int LW = cnt_width(LONG_MS + 1);
  localparam logic IDLE_LVL = ACTIVE_LOW != 0;
  logic [1:0] sync;
  logic raw, differ, accept, press_evt, release_evt, long_nxt;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lcnt, lcnt_nxt;
  lp_state_e state, state_nxt;
  assign raw = sync[1] ^ IDLE_LVL;
  assign differ = raw != key_state;
  assign accept = differ && cnt == CW'(DEBOUNCE_CNT - 1);
  assign press_evt = accept && raw;
  assign release_evt = accept && !raw;
  // Synchroniser resets to the released level so reset release never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync <= {2{IDLE_LVL}};
      cnt <= '0;
      key_state <= 1'b0;
      key_press <= 1'b0;
      key_release <= 1'b0;
      key_long <= 1'b0;
      state <= LP_IDLE;
      lcnt <= '0;
    end else begin
      sync <= {sync[0], key_in};
      cnt <= (accept || !differ) ? '0 : cnt + CW'(1);
      key_state <= accept ? raw : key_state;
      key_press <= press_evt;
      key_release <= release_evt;
      key_long <= long_nxt;
      state <= state_nxt;
      lcnt <= lcnt_nxt;
    end
  end
  // A release accepted on the firing tick leaves HOLD first, so it suppresses key_long.
  always_comb begin
    state_nxt = state;
    lcnt_nxt = lcnt;
    long_nxt = 1'b0;
    unique case (state)
      LP_IDLE: if (press_evt) begin
        state_nxt = LP_HOLD;
        lcnt_nxt = '0;
      end
      LP_HOLD: if (release_evt) state_nxt = LP_IDLE;
      else if (tick) begin
        lcnt_nxt = lcnt + LW'(1);
        if (lcnt == LW'(LONG_MS - 1)) begin
          long_nxt = 1'b1;
          state_nxt = LP_DONE;
        end
      end
      LP_DONE: if (release_evt) state_nxt = LP_IDLE;
      default: state_nxt = LP_IDLE;
    endcase
  end
endmodule

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: multi-key debouncer with press/release/long-press pulses and a shared ms prescaler.
module key_debounce_multi
  import key_debounce_multi_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int MS_CNT       = DEF_MS_CNT,
  parameter int LONG_MS      = DEF_LONG_MS,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);
  localparam int PW = cnt_width(MS_CNT);
  logic [PW-1:0] ms_cnt;
  logic tick;
  assign tick = ms_cnt == PW'(MS_CNT - 1);
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ms_cnt <= '0;
    else ms_cnt <= tick ? '0 : ms_cnt + PW'(1);
  end
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .LONG_MS     (LONG_MS),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_in     (key_in[i]),
      .tick       (tick),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end
endmodule
